// File: rtl/main.sv
// Registered 8-bit ALU with a 2-bit control FSM and a result accumulator.
// Each clock it loads num1/num2 (load) or chains the previous result as
// operand A (persist), applies one one-hot-selected op and registers it.
// Ports:
//   clk        rising-edge clock
//   on         enable; 0 forces OFF and clears the result
//   rst        asynchronous active-high reset
//   in_sel     one-hot mode: [2] persist, [1] load, [0] clear
//   num1       operand A for load
//   num2       operand B for load and persist
//   out_sel    one-hot op: [6]ADD [5]SUB [4]MUL [3]AND [2]OR [1]XOR [0]NOT
//   out        registered result (the accumulator)
//   currState  registered FSM state
//   nextState  combinational next FSM state (OFF while rst is high)
module main #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             on,
    input  logic             rst,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [6:0]       out_sel,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       currState,
    output logic [1:0]       nextState
);

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_READY = 2'b01,
        S_RUN   = 2'b10,
        S_ERR   = 2'b11
    } state_t;

    localparam logic [2:0] SEL_CLEAR   = 3'b001;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_PERSIST = 3'b100;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;

    // Operand A is the accumulator in persist mode, num1 otherwise.
    assign op_a = (in_sel == SEL_PERSIST) ? out : num1;
    assign op_b = num2;

    // Modulo-2^WIDTH ALU; carries, borrows and high product bits are dropped.
    always_comb begin
        alu_res = '0;
        case (out_sel)
            7'b1000000: alu_res = op_a + op_b;
            7'b0100000: alu_res = op_a - op_b;
            7'b0010000: alu_res = op_a * op_b;
            7'b0001000: alu_res = op_a & op_b;
            7'b0000100: alu_res = op_a | op_b;
            7'b0000010: alu_res = op_a ^ op_b;
            7'b0000001: alu_res = ~op_a;
            default:    alu_res = '0;
        endcase
    end

    // Next state and next result in priority order; an unrecognised in_sel
    // holds both state and result, even when that state is RUN.
    always_comb begin
        state_d = state_q;
        out_d   = out;
        if (!on) begin
            state_d = S_OFF;
            out_d   = '0;
        end else if (in_sel == SEL_CLEAR) begin
            state_d = S_READY;
            out_d   = '0;
        end else if ((in_sel == SEL_LOAD) || (in_sel == SEL_PERSIST)) begin
            if ($onehot(out_sel)) begin
                state_d = S_RUN;
                out_d   = alu_res;
            end else begin
                state_d = S_ERR;
            end
        end
    end

    assign nextState = rst ? 2'(S_OFF) : 2'(state_d);
    assign currState = 2'(state_q);

    // State and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_OFF;
            out     <= '0;
        end else begin
            state_q <= state_d;
            out     <= out_d;
        end
    end

endmodule

// File: tb/tb_main.sv
// Scoreboarded directed bench for the ALU/FSM block.
module tb_main;

    logic       clk;
    logic       on;
    logic       rst;
    logic [2:0] in_sel;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [6:0] out_sel;
    logic [7:0] out;
    logic [1:0] currState;
    logic [1:0] nextState;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] out;
        logic [1:0] st;
        string      tag;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_out   = 8'h00;
    logic [1:0] m_state = 2'b00;

    localparam logic [6:0] OP_ADD = 7'b1000000;
    localparam logic [6:0] OP_SUB = 7'b0100000;
    localparam logic [6:0] OP_MUL = 7'b0010000;
    localparam logic [6:0] OP_AND = 7'b0001000;
    localparam logic [6:0] OP_OR  = 7'b0000100;
    localparam logic [6:0] OP_XOR = 7'b0000010;
    localparam logic [6:0] OP_NOT = 7'b0000001;

    main #(.WIDTH(8)) dut (
        .clk       (clk),
        .on        (on),
        .rst       (rst),
        .in_sel    (in_sel),
        .num1      (num1),
        .num2      (num2),
        .out_sel   (out_sel),
        .out       (out),
        .currState (currState),
        .nextState (nextState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_alu(input logic [7:0] a, input logic [7:0] b,
                                             input logic [6:0] op);
        logic [15:0] prod;
        prod = 16'(a) * 16'(b);
        if (op == OP_ADD)      return 8'((9'(a) + 9'(b)) & 9'h0FF);
        else if (op == OP_SUB) return 8'((9'h100 + 9'(a) - 9'(b)) & 9'h0FF);
        else if (op == OP_MUL) return prod[7:0];
        else if (op == OP_AND) return a & b;
        else if (op == OP_OR)  return a | b;
        else if (op == OP_XOR) return a ^ b;
        else                   return ~a;
    endfunction

    function automatic logic is_onehot7(input logic [6:0] v);
        int n = 0;
        for (int i = 0; i < 7; i++) if (v[i]) n++;
        return n == 1;
    endfunction

    // Drive one cycle of stimulus, check nextState, queue the expected
    // post-edge result, clock, then pop and compare.
    task automatic step(input logic o, input logic [2:0] is, input logic [7:0] a,
                        input logic [7:0] b, input logic [6:0] op, input string tag);
        exp_t       e;
        logic [1:0] ns;
        logic [7:0] no;
        on = o; in_sel = is; num1 = a; num2 = b; out_sel = op;
        ns = m_state;
        no = m_out;
        if (!o) begin
            ns = 2'b00; no = 8'h00;
        end else if (is == 3'b001) begin
            ns = 2'b01; no = 8'h00;
        end else if (is == 3'b010 || is == 3'b100) begin
            if (is_onehot7(op)) begin
                ns = 2'b10;
                no = model_alu((is == 3'b100) ? m_out : a, b, op);
            end else begin
                ns = 2'b11;
            end
        end
        #1;
        check({tag, "_ns"}, {6'b0, nextState}, {6'b0, ns});
        e.out = no; e.st = ns; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_out"}, out, e.out);
            check({e.tag, "_st"}, {6'b0, currState}, {6'b0, e.st});
        end
        m_out   = no;
        m_state = ns;
    endtask

    initial begin
        rst = 1'b1; on = 1'b0; in_sel = 3'b000;
        num1 = 8'h00; num2 = 8'h00; out_sel = 7'b0;
        #1;
        check("rst_out", out, 8'h00);
        check("rst_st", {6'b0, currState}, 8'h00);
        check("rst_ns", {6'b0, nextState}, 8'h00);
        #2 rst = 1'b0;

        step(1'b0, 3'b010, 8'h57, 8'h1A, OP_ADD, "off_hold");
        check("off_out_const", out, 8'h00);

        // Sweep every op on a fresh load.
        step(1'b1, 3'b010, 8'h57, 8'h1A, OP_ADD, "ld_add"); check("ld_add_c", out, 8'h71);
        step(1'b1, 3'b010, 8'h57, 8'h1A, OP_SUB, "ld_sub"); check("ld_sub_c", out, 8'h3D);
        step(1'b1, 3'b010, 8'h57, 8'h1A, OP_MUL, "ld_mul"); check("ld_mul_c", out, 8'hD6);
        step(1'b1, 3'b010, 8'h57, 8'h1A, OP_AND, "ld_and"); check("ld_and_c", out, 8'h12);
        step(1'b1, 3'b010, 8'h57, 8'h1A, OP_OR,  "ld_or");  check("ld_or_c",  out, 8'h5F);
        step(1'b1, 3'b010, 8'h57, 8'h1A, OP_XOR, "ld_xor"); check("ld_xor_c", out, 8'h4D);
        step(1'b1, 3'b010, 8'h57, 8'h1A, OP_NOT, "ld_not"); check("ld_not_c", out, 8'hA8);
        check("run_st_c", {6'b0, currState}, 8'h02);

        // Accumulator chaining; num1 is deliberately junk in persist mode.
        step(1'b1, 3'b010, 8'h57, 8'h1A, OP_ADD, "chain_ld"); check("chain_ld_c", out, 8'h71);
        step(1'b1, 3'b100, 8'hEE, 8'h1A, OP_ADD, "chain_p1"); check("chain_p1_c", out, 8'h8B);
        step(1'b1, 3'b100, 8'hEE, 8'h1A, OP_ADD, "chain_p2"); check("chain_p2_c", out, 8'hA5);
        step(1'b1, 3'b100, 8'h00, 8'h05, OP_SUB, "chain_sub"); check("chain_sub_c", out, 8'hA0);

        // Wrap-around.
        step(1'b1, 3'b010, 8'hFF, 8'h01, OP_ADD, "wrap_add"); check("wrap_add_c", out, 8'h00);
        step(1'b1, 3'b010, 8'h00, 8'h01, OP_SUB, "wrap_sub"); check("wrap_sub_c", out, 8'hFF);
        step(1'b1, 3'b010, 8'hFF, 8'hFF, OP_MUL, "wrap_mul"); check("wrap_mul_c", out, 8'h01);

        // Invalid op selection -> ERR with result held, then clear.
        step(1'b1, 3'b010, 8'h12, 8'h34, 7'b0000011, "err_in");
        check("err_st_c", {6'b0, currState}, 8'h03);
        check("err_out_c", out, 8'h01);
        step(1'b1, 3'b000, 8'h12, 8'h34, OP_ADD, "err_hold");
        step(1'b1, 3'b001, 8'h12, 8'h34, OP_ADD, "clear");
        check("clear_st_c", {6'b0, currState}, 8'h01);
        check("clear_out_c", out, 8'h00);

        // Hold in RUN on a non-one-hot in_sel, with a valid op present.
        step(1'b1, 3'b010, 8'h30, 8'h0C, OP_OR, "run_ld"); check("run_ld_c", out, 8'h3C);
        step(1'b1, 3'b000, 8'h01, 8'h01, OP_ADD, "hold_000"); check("hold_000_c", out, 8'h3C);
        step(1'b1, 3'b110, 8'h01, 8'h01, OP_ADD, "hold_110"); check("hold_110_c", out, 8'h3C);

        // on=0 overrides a valid load.
        step(1'b0, 3'b010, 8'h01, 8'h01, OP_ADD, "on_off");
        step(1'b1, 3'b010, 8'h40, 8'h02, OP_SUB, "rerun"); check("rerun_c", out, 8'h3E);

        // Asynchronous reset between edges.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_out", out, 8'h00);
        check("arst_st", {6'b0, currState}, 8'h00);
        check("arst_ns", {6'b0, nextState}, 8'h00);
        m_out = 8'h00; m_state = 2'b00;
        @(posedge clk); #1;
        check("arst_hold_out", out, 8'h00);
        rst = 1'b0;
        step(1'b1, 3'b010, 8'h57, 8'h1A, OP_ADD, "post_rst"); check("post_rst_c", out, 8'h71);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
